// File: rtl/shift_exec.sv
// Single-stage shift/rotate unit with flags and a 2-entry in-order result buffer.
// Result and flags read as zero whenever the buffer is empty, including during reset.
module shift_exec #(
  parameter int WIDTH = 16,
  localparam int SEL = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [SEL-1:0]   amount,
  input  logic [WIDTH-1:0] operand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             illegal
);

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_ROR = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;

  logic [2*WIDTH-1:0] rol_dbl;
  logic [2*WIDTH-1:0] ror_dbl;
  logic [SEL-1:0]     amt_neg;
  logic [SEL-1:0]     amt_m1;
  logic [WIDTH-1:0]   calc_result;
  logic               calc_carry;
  logic               calc_illegal;
  logic [WIDTH+3:0]   calc_entry;

  // Rotates use a doubled operand so amount 0 needs no special case.
  assign rol_dbl = {operand, operand} << amount;
  assign ror_dbl = {operand, operand} >> amount;
  assign amt_neg = SEL'(0) - amount;
  assign amt_m1  = amount - SEL'(1);

  always_comb begin
    calc_result  = operand;
    calc_carry   = 1'b0;
    calc_illegal = 1'b0;
    case (op)
      OP_ROL: begin
        calc_result = rol_dbl[2*WIDTH-1:WIDTH];
        calc_carry  = calc_result[0];
      end
      OP_ROR: begin
        calc_result = ror_dbl[WIDTH-1:0];
        calc_carry  = calc_result[WIDTH-1];
      end
      OP_SHL: begin
        calc_result = operand << amount;
        calc_carry  = operand[amt_neg];
      end
      OP_SHR: begin
        calc_result = operand >> amount;
        calc_carry  = operand[amt_m1];
      end
      OP_SRA: begin
        calc_result = WIDTH'($signed(operand) >>> amount);
        calc_carry  = operand[amt_m1];
      end
      default: calc_illegal = 1'b1;
    endcase
    if (amount == '0) calc_carry = 1'b0;
  end

  assign calc_entry = {calc_result, calc_carry, (calc_result == '0),
                       calc_result[WIDTH-1], calc_illegal};

  logic [WIDTH+3:0] entry_mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             accept;
  logic             consume;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count > 2'd0);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (accept) wr_ptr <= ~wr_ptr;
      if (consume) rd_ptr <= ~rd_ptr;
      case ({accept, consume})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: it is only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (accept) entry_mem[wr_ptr] <= calc_entry;
  end

  assign {result, carry, zero, negative, illegal} =
    out_valid ? entry_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_shift_exec.sv
// Self-checking bench for shift_exec: directed vector table, handshake corner
// sequences and randomized traffic against a queue-based reference model.
module tb_shift_exec;
  localparam int W = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [3:0]    amount;
  logic [W-1:0]  operand;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          carry;
  logic          zero;
  logic          negative;
  logic          illegal;

  int checks = 0;
  int errors = 0;

  shift_exec #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .amount(amount), .operand(operand), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .carry(carry), .zero(zero),
    .negative(negative), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] r;
    logic [3:0]   f;   // {carry, zero, negative, illegal}
  } entry_t;

  typedef struct {
    logic [2:0]   op;
    logic [3:0]   amt;
    logic [W-1:0] d;
    logic [W-1:0] r;
    logic [3:0]   f;
  } vec_t;

  entry_t mq[$];

  function automatic entry_t ref_op(input logic [2:0] o, input logic [3:0] amt,
                                    input logic [W-1:0] d);
    entry_t e;
    int a;
    logic [W-1:0] r;
    logic c, il;
    a = int'(amt);
    r = d;
    c = 1'b0;
    il = 1'b0;
    case (o)
      3'd0: begin
        for (int i = 0; i < W; i++) r[(i + a) % W] = d[i];
        c = (a == 0) ? 1'b0 : r[0];
      end
      3'd1: begin
        for (int i = 0; i < W; i++) r[i] = d[(i + a) % W];
        c = (a == 0) ? 1'b0 : r[W-1];
      end
      3'd2: begin
        for (int i = 0; i < W; i++) r[i] = (i >= a) ? d[i - a] : 1'b0;
        c = (a == 0) ? 1'b0 : d[W - a];
      end
      3'd3, 3'd4: begin
        for (int i = 0; i < W; i++)
          r[i] = (i + a < W) ? d[i + a] : ((o == 3'd4) ? d[W-1] : 1'b0);
        c = (a == 0) ? 1'b0 : d[a - 1];
      end
      default: il = 1'b1;
    endcase
    e.r = r;
    e.f = {c, (r == '0), r[W-1], il};
    return e;
  endfunction

  // Reference buffer: accept when fewer than 2 held, consume when non-empty.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else if (mq.size() > 0 && out_ready) begin
      if (in_valid && mq.size() < 2) mq.push_back(ref_op(op, amount, operand));
      void'(mq.pop_front());
    end else if (in_valid && mq.size() < 2) begin
      mq.push_back(ref_op(op, amount, operand));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    if (mq.size() > 0) begin
      chk("head_result", 32'(result), 32'(mq[0].r));
      chk("head_flags", 32'({carry, zero, negative, illegal}), 32'(mq[0].f));
    end else begin
      chk("idle_result", 32'(result), 32'h0);
      chk("idle_flags", 32'({carry, zero, negative, illegal}), 32'h0);
    end
  endtask

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{3'd0, 4'd1,  16'h8001, 16'h0003, 4'b1000};
    vecs[1]  = '{3'd4, 4'd15, 16'h8000, 16'hFFFF, 4'b0010};
    vecs[2]  = '{3'd3, 4'd1,  16'h0001, 16'h0000, 4'b1100};
    vecs[3]  = '{3'd0, 4'd0,  16'hA5C3, 16'hA5C3, 4'b0010};
    vecs[4]  = '{3'd1, 4'd0,  16'hA5C3, 16'hA5C3, 4'b0010};
    vecs[5]  = '{3'd2, 4'd0,  16'hA5C3, 16'hA5C3, 4'b0010};
    vecs[6]  = '{3'd3, 4'd0,  16'hA5C3, 16'hA5C3, 4'b0010};
    vecs[7]  = '{3'd4, 4'd0,  16'hA5C3, 16'hA5C3, 4'b0010};
    vecs[8]  = '{3'd7, 4'd5,  16'h1234, 16'h1234, 4'b0001};
    vecs[9]  = '{3'd2, 4'd2,  16'h4001, 16'h0004, 4'b1000};
    vecs[10] = '{3'd1, 4'd1,  16'h0001, 16'h8000, 4'b1010};
    vecs[11] = '{3'd5, 4'd3,  16'h0000, 16'h0000, 4'b0101};
    vecs[12] = '{3'd2, 4'd1,  16'h8000, 16'h0000, 4'b1100};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; amount = 4'd0; operand = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_outputs", 32'({result, carry, zero, negative, illegal}), 32'h0);
    rst_n = 1'b1;

    // Directed vectors, one at a time with 1-cycle latency.
    for (int k = 0; k < 13; k++) begin
      in_valid = 1'b1; op = vecs[k].op; amount = vecs[k].amt; operand = vecs[k].d;
      @(negedge clk);
      check_state();
      chk("vec_valid", 32'(out_valid), 32'h1);
      chk("vec_result", 32'(result), 32'(vecs[k].r));
      chk("vec_flags", 32'({carry, zero, negative, illegal}), 32'(vecs[k].f));
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check_state();
      chk("vec_drain", 32'(out_valid), 32'h0);
      out_ready = 1'b0;
    end

    // Backpressure: A, B accepted, C held until a slot frees.
    in_valid = 1'b1; op = 3'd0; amount = 4'd3; operand = 16'h1111;
    @(negedge clk); check_state();
    chk("bp_ready_after_a", 32'(in_ready), 32'h1);
    op = 3'd2; operand = 16'h2222;
    @(negedge clk); check_state();
    chk("bp_ready_after_b", 32'(in_ready), 32'h0);
    op = 3'd3; operand = 16'h3333;
    @(negedge clk); check_state();
    chk("bp_full_ready", 32'(in_ready), 32'h0);
    chk("bp_head_a", 32'(result), 32'h8888);
    out_ready = 1'b1;
    @(negedge clk); check_state();
    chk("bp_head_b", 32'(result), 32'h1110);
    @(negedge clk); check_state();
    chk("bp_head_c", 32'(result), 32'h0666);
    in_valid = 1'b0;
    @(negedge clk); check_state();
    chk("bp_empty", 32'(out_valid), 32'h0);

    // Streaming: one result per cycle, occupancy stays at one.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; op = 3'($urandom_range(0, 4));
      amount = 4'($urandom_range(0, 15)); operand = 16'($urandom);
      @(negedge clk); check_state();
      chk("stream_in_ready", 32'(in_ready), 32'h1);
      chk("stream_out_valid", 32'(out_valid), 32'h1);
    end
    in_valid = 1'b0;
    @(negedge clk); check_state();
    out_ready = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      op = 3'($urandom_range(0, 7));
      amount = 4'($urandom_range(0, 15));
      operand = 16'($urandom);
      @(negedge clk); check_state();
    end

    // Asynchronous reset with a full buffer.
    in_valid = 1'b1; out_ready = 1'b0; op = 3'd1; amount = 4'd4; operand = 16'hBEEF;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk); check_state();
    chk("pre_rst_full", 32'(in_ready), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    chk("async_rst_ready", 32'(in_ready), 32'h1);
    chk("async_rst_outputs", 32'({result, carry, zero, negative, illegal}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); check_state();
      chk("post_rst_no_stale", 32'(out_valid), 32'h0);
    end
    in_valid = 1'b1; op = 3'd0; amount = 4'd1; operand = 16'h8001;
    @(negedge clk); check_state();
    chk("post_rst_result", 32'(result), 32'h0003);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); check_state();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
